nto1_rr_arb_stage: RTL and testbench

//  Registered N-requester round-robin arbiter: the stage that feeds an N:1 M-bit selection path.
//  - Takes N packed M-bit sources, each with its own valid/ready handshake.
//  - Picks one source fairly and drives that source's index as a select.
//  - Captures the chosen word in a one-entry output register with a valid/ready handshake.
//  - Sits between independent producers and a single shared consumer (bus, FIFO, datapath).

---
 rtl/nto1_arb_pkg.sv | 29 ++
 rtl/rr_grant_gen.sv | 20 ++
 rtl/nto1_rr_arb_stage.sv | 57 +++++
 tb/tb_nto1_rr_arb_stage.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/nto1_arb_pkg.sv
// nto1_arb_pkg: shared types and helpers for the round-robin arbiter stage
package nto1_arb_pkg;

    localparam int MAX_N = 64;

    typedef logic [MAX_N-1:0] req_t;

    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

    // Lowest set bit at or above ptr; if none, lowest set bit overall (wrap).
    function automatic int unsigned rr_pick(input req_t req, input int unsigned ptr);
        req_t masked;
        req_t src;
        logic found;
        masked = req & ~((req_t'(1) << ptr) - req_t'(1));
        src    = (|masked) ? masked : req;
        found  = 1'b0;
        rr_pick = 0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            if (!found && src[i]) begin
                rr_pick = i;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/rr_grant_gen.sv
// rr_grant_gen: combinational find-first-from-pointer grant index
module rr_grant_gen
    import nto1_arb_pkg::*;
#(
    parameter  int N = 16,
    localparam int W = idx_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] gnt_idx,
    output logic         gnt_any
);

    // Grant is the first requester found scanning upward from ptr with wrap
    always_comb begin
        gnt_any = |req;
        gnt_idx = W'(rr_pick(req_t'(req), 32'(ptr)));
    end

endmodule

// File: rtl/nto1_rr_arb_stage.sv
// nto1_rr_arb_stage: registered N-to-1 round-robin arbiter with one-entry output register
module nto1_rr_arb_stage
    import nto1_arb_pkg::*;
#(
    parameter  int N = 16,
    parameter  int M = 32,
    localparam int W = idx_w(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*M-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    output logic [M-1:0]   out_data,
    output logic [W-1:0]   out_sel,
    output logic           out_valid,
    input  logic           out_ready
);

    logic [W-1:0] ptr;
    logic [W-1:0] gnt_idx;
    logic         gnt_any;
    logic         load;
    logic         accept;

    rr_grant_gen #(.N(N)) u_grant (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // Output register can take a new word when empty or being drained
    always_comb begin
        load     = !out_valid || out_ready;
        accept   = load && gnt_any;
        in_ready = accept ? N'(1) << gnt_idx : '0;
    end

    // Capture the winner and advance the pointer past it; stall holds everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load) begin
            out_valid <= gnt_any;
            if (gnt_any) begin
                out_data <= in_data[gnt_idx*M +: M];
                out_sel  <= gnt_idx;
                ptr      <= (gnt_idx == W'(N - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nto1_rr_arb_stage.sv
// tb_nto1_rr_arb_stage: directed and random checks of the round-robin arbiter stage
module tb_nto1_rr_arb_stage;

    localparam int N  = 16;
    localparam int M  = 32;
    localparam int W  = 4;
    localparam int NB = 5;
    localparam int MB = 8;
    localparam int WB = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*M-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [M-1:0]   out_data;
    logic [W-1:0]   out_sel;
    logic           out_valid;
    logic           out_ready;

    logic [NB*MB-1:0] b_in_data;
    logic [NB-1:0]    b_in_valid;
    logic [NB-1:0]    b_in_ready;
    logic [MB-1:0]    b_out_data;
    logic [WB-1:0]    b_out_sel;
    logic             b_out_valid;
    logic             b_out_ready;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    nto1_rr_arb_stage #(.N(N), .M(M)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
    );

    nto1_rr_arb_stage #(.N(NB), .M(MB)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_sel(b_out_sel), .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    function automatic logic [M-1:0] pat(input int i);
        return {4'(i), 28'hA5A5A5A};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0]  vld;
        logic [27:0]   seq [N];
        int            wt [N];
        logic          mv;
        logic [W-1:0]  msel;
        logic [M-1:0]  mdata;
        int            mptr;
        logic          mload;
        int            g;
        logic [N-1:0]  exp_rdy;

        rst_n       = 1'b0;
        in_valid    = '0;
        out_ready   = 1'b0;
        b_in_valid  = '0;
        b_out_ready = 1'b0;
        for (int i = 0; i < N; i++) in_data[i*M +: M] = pat(i);
        for (int i = 0; i < NB; i++) b_in_data[i*MB +: MB] = {4'(i), 4'h5};

        #12;
        chk("rst_valid", 64'(out_valid), 0);
        chk("rst_sel", 64'(out_sel), 0);
        chk("rst_data", 64'(out_data), 0);
        rst_n = 1'b1;

        in_valid  = '1;
        out_ready = 1'b1;
        #1;
        chk("t1_first_ready", 64'(in_ready), 64'h0001);
        tick();
        for (int i = 0; i < 32; i++) begin
            chk("t2_valid", 64'(out_valid), 1);
            chk("t2_sel", 64'(out_sel), 64'(i % 16));
            chk("t2_data", 64'(out_data), 64'(pat(i % 16)));
            chk("t2_ready", 64'(in_ready), 64'(16'(1) << ((i + 1) % 16)));
            if (i != 31) tick();
        end

        #2 rst_n = 1'b0;
        #1;
        chk("t1_mid_valid", 64'(out_valid), 0);
        chk("t1_mid_sel", 64'(out_sel), 0);
        chk("t1_mid_data", 64'(out_data), 0);
        rst_n = 1'b1;
        tick();
        chk("t1_regrant_sel", 64'(out_sel), 0);
        chk("t1_regrant_valid", 64'(out_valid), 1);

        tick();
        tick();
        tick();
        chk("t3_sel_pre", 64'(out_sel), 3);
        out_ready = 1'b0;
        #1;
        chk("t3_ready_stall", 64'(in_ready), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_hold_sel", 64'(out_sel), 3);
            chk("t3_hold_data", 64'(out_data), 64'(pat(3)));
            chk("t3_hold_valid", 64'(out_valid), 1);
            chk("t3_hold_ready", 64'(in_ready), 0);
        end
        out_ready = 1'b1;
        #1;
        chk("t3_release_ready", 64'(in_ready), 64'h0010);
        tick();
        chk("t3_release_sel", 64'(out_sel), 4);

        for (int i = 0; i < 9; i++) tick();
        chk("t4_sel_13", 64'(out_sel), 13);
        in_valid = 16'h0021;
        #1;
        chk("t4_wrap_ready", 64'(in_ready), 64'h0001);
        tick();
        chk("t4_sel_0", 64'(out_sel), 0);
        chk("t4_next_ready", 64'(in_ready), 64'h0020);
        tick();
        chk("t4_sel_5", 64'(out_sel), 5);
        in_valid = '0;
        #1;
        chk("t4_idle_ready", 64'(in_ready), 0);
        tick();
        chk("t4_idle_valid", 64'(out_valid), 0);
        chk("t4_idle_sel", 64'(out_sel), 5);
        in_valid = 16'h0021;
        #1;
        chk("t4_ptr6_wrap", 64'(in_ready), 64'h0001);
        in_valid = 16'h0041;
        #1;
        chk("t4_ptr6_exact", 64'(in_ready), 64'h0040);
        in_valid = '0;

        b_in_valid  = '1;
        b_out_ready = 1'b1;
        #1;
        chk("t5_first_ready", 64'(b_in_ready), 64'h01);
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("t5_sel", 64'(b_out_sel), 64'(i % 5));
            chk("t5_data", 64'(b_out_data), 64'({4'(i % 5), 4'h5}));
            chk("t5_ready", 64'(b_in_ready), 64'(5'(1) << ((i + 1) % 5)));
            if (i != 9) tick();
        end
        b_in_valid = '0;

        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        vld   = '0;
        mv    = 1'b0;
        msel  = '0;
        mdata = '0;
        mptr  = 0;
        for (int i = 0; i < N; i++) begin
            seq[i] = 28'(i * 1000);
            wt[i]  = 0;
        end
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!vld[i] && ($urandom_range(1, 0) == 1)) begin
                    vld[i] = 1'b1;
                    wt[i]  = 0;
                end
                in_data[i*M +: M] = {4'(i), seq[i]};
            end
            in_valid  = vld;
            out_ready = ($urandom_range(3, 0) != 0);
            #1;
            chk("t6_valid", 64'(out_valid), 64'(mv));
            if (mv) begin
                chk("t6_sel", 64'(out_sel), 64'(msel));
                chk("t6_data", 64'(out_data), 64'(mdata));
            end
            mload = !mv || out_ready;
            g = -1;
            for (int k = 0; k < N; k++) begin
                if (g < 0 && vld[(mptr + k) % N]) g = (mptr + k) % N;
            end
            exp_rdy = (mload && g >= 0) ? 16'(1) << g : '0;
            chk("t6_ready", 64'(in_ready), 64'(exp_rdy));
            tick();
            if (mload) begin
                mv = (g >= 0);
                if (g >= 0) begin
                    mdata = {4'(g), seq[g]};
                    msel  = W'(g);
                    mptr  = (g + 1) % N;
                    for (int i = 0; i < N; i++) if (i != g && vld[i]) wt[i]++;
                    chk("t6_gap", 64'(wt[g] <= N - 1), 1);
                    vld[g] = 1'b0;
                    seq[g] = seq[g] + 28'd1;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
